// File: rtl/aes_fpga_ctrl_pkg.sv
// aes_fpga_pkg: FSM encoding, default sizes and display paging helpers
// shared by the AES board controller and its bench.
package aes_fpga_pkg;

   localparam int AES_DATA_W  = 128;
   localparam int AES_TIMEOUT = 4096;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_CHECK,
      ST_DONE,
      ST_LOAD_RT,
      ST_CHECK_RT
   } state_e;

   function automatic int num_groups(input int data_w, input int num_digits);
      return data_w / (4 * num_digits);
   endfunction

   function automatic int grp_w(input int data_w, input int num_digits);
      int n;
      n = num_groups(data_w, num_digits);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aes_fpga_ctrl_debounce.sv
// btn_debounce: synchronises a raw button, accepts a level once it has held
// for DEBOUNCE_CYCLES and emits a one-cycle pulse on each accepted rise.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any disagreement run shorter than the hold time restarts from zero.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      pulse_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/aes_fpga_ctrl.sv
// aes_fpga_ctrl: board test controller running ROM vectors through the AES core.
// Define AES_CTRL_ROUNDTRIP_EN to decrypt each ciphertext back and report rt_ok.
module aes_fpga_ctrl
   import aes_fpga_pkg::*;
#(
   parameter int DATA_W          = AES_DATA_W,
   parameter int NUM_DIGITS      = 8,
   parameter int VEC_SEL_W       = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TIMEOUT_CYCLES  = AES_TIMEOUT
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 btn_start,
   input  logic                                 btn_mode,
   input  logic                                 btn_prev,
   input  logic                                 btn_next,
   input  logic [VEC_SEL_W-1:0]                 vec_sel_in,
   input  logic [DATA_W-1:0]                    vec_data,
   input  logic [DATA_W-1:0]                    vec_key,
   input  logic [DATA_W-1:0]                    vec_exp,
   output logic [VEC_SEL_W-1:0]                 vec_sel,
   output logic                                 vec_mode,
   output logic                                 core_start,
   output logic                                 core_enc_dec,
   output logic [DATA_W-1:0]                    core_data_in,
   output logic [DATA_W-1:0]                    core_key,
   input  logic [DATA_W-1:0]                    core_data_out,
   input  logic                                 core_ready,
   output logic [4*NUM_DIGITS-1:0]              disp_data,
   output logic [grp_w(DATA_W, NUM_DIGITS)-1:0] disp_group,
   output logic                                 busy,
   output logic                                 pass,
   output logic                                 fail,
   output logic                                 timeout,
   output logic                                 rt_ok,
   output logic [7:0]                           run_count
);

   localparam int DISP_W     = 4 * NUM_DIGITS;
   localparam int NUM_GROUPS = num_groups(DATA_W, NUM_DIGITS);
   localparam int GRP_W      = grp_w(DATA_W, NUM_DIGITS);
   localparam int TO_W       = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic start_p, mode_p, prev_p, next_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_start), .pulse_o(start_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .pulse_o(mode_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .pulse_o(prev_p)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk(clk), .rst_n(rst_n), .btn_i(btn_next), .pulse_o(next_p)
   );

   state_e              state_q, state_d;
   logic [VEC_SEL_W-1:0] sel_q, sel_d;
   logic                mode_q, mode_d;
   logic [GRP_W-1:0]    grp_q, grp_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [DATA_W-1:0]   key_q, key_d;
   logic [DATA_W-1:0]   exp_q, exp_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                enc_q, enc_d;
   logic                pass_q, pass_d;
   logic                fail_q, fail_d;
   logic                tmo_q, tmo_d;
   logic [7:0]          run_q, run_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                idle;
`ifdef AES_CTRL_ROUNDTRIP_EN
   logic [DATA_W-1:0]   pt_q, pt_d;
   logic                rtph_q, rtph_d;
   logic                rtok_q, rtok_d;
`endif

   assign idle = (state_q == ST_IDLE) || (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      mode_d  = mode_q;
      grp_d   = grp_q;
      din_d   = din_q;
      key_d   = key_q;
      exp_d   = exp_q;
      res_d   = res_q;
      enc_d   = enc_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      tmo_d   = tmo_q;
      run_d   = run_q;
      to_d    = to_q;
`ifdef AES_CTRL_ROUNDTRIP_EN
      pt_d    = pt_q;
      rtph_d  = rtph_q;
      rtok_d  = rtok_q;
`endif

      if (idle) begin
         sel_d = vec_sel_in;
         if (mode_p) mode_d = ~mode_q;
      end

      // Paging works in every state so a result can be browsed mid-run.
      if (next_p && !prev_p) begin
         grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
      end else if (prev_p && !next_p) begin
         grp_d = (grp_q == '0) ? GRP_LAST : grp_q - GRP_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_p) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            din_d   = vec_data;
            key_d   = vec_key;
            exp_d   = vec_exp;
            enc_d   = mode_q;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            tmo_d   = 1'b0;
`ifdef AES_CTRL_ROUNDTRIP_EN
            rtok_d  = 1'b0;
            rtph_d  = 1'b0;
`endif
            state_d = ST_START;
         end
         ST_START: begin
            to_d    = '0;
            state_d = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (!core_ready) begin
               state_d = ST_WAIT_HI;
            end else if (to_q == TO_LAST) begin
               tmo_d   = 1'b1;
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         ST_WAIT_HI: begin
            if (core_ready) begin
`ifdef AES_CTRL_ROUNDTRIP_EN
               if (rtph_q) begin
                  state_d = ST_CHECK_RT;
               end else begin
                  res_d   = core_data_out;
                  state_d = ST_CHECK;
               end
`else
               res_d   = core_data_out;
               state_d = ST_CHECK;
`endif
            end else if (to_q == TO_LAST) begin
               tmo_d   = 1'b1;
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         ST_CHECK: begin
            pass_d  = (res_q == exp_q);
            fail_d  = (res_q != exp_q);
            if (run_q != 8'hFF) run_d = run_q + 8'd1;
            state_d = ST_DONE;
`ifdef AES_CTRL_ROUNDTRIP_EN
            if (enc_q) state_d = ST_LOAD_RT;
`endif
         end
`ifdef AES_CTRL_ROUNDTRIP_EN
         // Feed the ciphertext back for decryption; res_q keeps it for display.
         ST_LOAD_RT: begin
            pt_d    = din_q;
            din_d   = res_q;
            enc_d   = 1'b0;
            rtph_d  = 1'b1;
            state_d = ST_START;
         end
         ST_CHECK_RT: begin
            rtok_d  = (core_data_out == pt_q);
            rtph_d  = 1'b0;
            state_d = ST_DONE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         mode_q  <= 1'b1;
         grp_q   <= '0;
         din_q   <= '0;
         key_q   <= '0;
         exp_q   <= '0;
         res_q   <= '0;
         enc_q   <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         tmo_q   <= 1'b0;
         run_q   <= '0;
         to_q    <= '0;
`ifdef AES_CTRL_ROUNDTRIP_EN
         pt_q    <= '0;
         rtph_q  <= 1'b0;
         rtok_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         mode_q  <= mode_d;
         grp_q   <= grp_d;
         din_q   <= din_d;
         key_q   <= key_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
         enc_q   <= enc_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         tmo_q   <= tmo_d;
         run_q   <= run_d;
         to_q    <= to_d;
`ifdef AES_CTRL_ROUNDTRIP_EN
         pt_q    <= pt_d;
         rtph_q  <= rtph_d;
         rtok_q  <= rtok_d;
`endif
      end
   end

   assign vec_sel      = sel_q;
   assign vec_mode     = mode_q;
   assign core_start   = (state_q == ST_START);
   assign core_enc_dec = enc_q;
   assign core_data_in = din_q;
   assign core_key     = key_q;
   assign disp_data    = res_q[int'(grp_q) * DISP_W +: DISP_W];
   assign disp_group   = grp_q;
   assign busy         = !idle;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = tmo_q;
   assign run_count    = run_q;
`ifdef AES_CTRL_ROUNDTRIP_EN
   assign rt_ok        = rtok_q;
`else
   assign rt_ok        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_fpga_ctrl.sv
// Bench for aes_fpga_ctrl: ROM and core models plus a result scoreboard.
// Build with AES_CTRL_ROUNDTRIP_EN to check the round-trip flow as well.
module tb_aes_fpga_ctrl;

   localparam int DW = 128;
   localparam int ND = 8;
   localparam int SW = 4;
   localparam int DB = 4;
   localparam int TO = 64;
   localparam int GW = aes_fpga_pkg::grp_w(DW, ND);

   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CTRL_ROUNDTRIP_EN
   localparam bit RT = 1'b1;
`else
   localparam bit RT = 1'b0;
`endif

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        tmo;
      logic        rt;
      logic [7:0]  run;
      logic [31:0] disp;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          btn_start = 1'b0, btn_mode = 1'b0;
   logic          btn_prev = 1'b0, btn_next = 1'b0;
   logic [SW-1:0] vec_sel_in = '0;
   logic [SW-1:0] vec_sel;
   logic          vec_mode;
   logic [DW-1:0] vec_data, vec_key, vec_exp;
   logic          core_start, core_enc_dec;
   logic [DW-1:0] core_data_in, core_key;
   logic [DW-1:0] core_data_out;
   logic          core_ready;
   logic [31:0]   disp_data;
   logic [GW-1:0] disp_group;
   logic          busy, pass, fail, timeout, rt_ok;
   logic [7:0]    run_count;

   res_t sb_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_starts = 0;
   int   last_start = 0;
   int   core_mode = 0;
   int   lat = 3;

   always #5 clk = ~clk;

   aes_fpga_ctrl #(
      .DATA_W(DW), .NUM_DIGITS(ND), .VEC_SEL_W(SW),
      .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_start(btn_start), .btn_mode(btn_mode),
      .btn_prev(btn_prev), .btn_next(btn_next),
      .vec_sel_in(vec_sel_in),
      .vec_data(vec_data), .vec_key(vec_key), .vec_exp(vec_exp),
      .vec_sel(vec_sel), .vec_mode(vec_mode),
      .core_start(core_start), .core_enc_dec(core_enc_dec),
      .core_data_in(core_data_in), .core_key(core_key),
      .core_data_out(core_data_out), .core_ready(core_ready),
      .disp_data(disp_data), .disp_group(disp_group),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
      .rt_ok(rt_ok), .run_count(run_count)
   );

   // Vector ROM: selection 0 is the FIPS-197 C.1 vector in either direction.
   assign vec_key  = KEY ^ {{(DW-SW){1'b0}}, vec_sel};
   assign vec_data = (vec_mode ? PT : CT) ^ {{(DW-SW){1'b0}}, vec_sel};
   assign vec_exp  = (vec_mode ? CT : PT) ^ {{(DW-SW){1'b0}}, vec_sel};

   function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic enc);
      if (enc && d == PT) return CT;
      if (!enc && d == CT) return PT;
      return ~d;
   endfunction

   // Core model: 0 = correct, 1 = wrong result, 2 = ready never returns.
   logic         m_ready = 1'b1;
   logic [7:0]   m_cnt = '0;
   logic [127:0] m_din = '0, m_out = '0;
   logic         m_enc = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_start) begin
         m_ready <= 1'b0;
         m_cnt   <= 8'(lat);
         m_din   <= core_data_in;
         m_enc   <= core_enc_dec;
      end else if (!m_ready && m_cnt != 0) begin
         m_cnt <= m_cnt - 8'd1;
         if (m_cnt == 8'd1 && core_mode != 2) begin
            m_ready <= 1'b1;
            m_out   <= (core_mode == 1) ? ~aes_ref(m_din, m_enc) : aes_ref(m_din, m_enc);
         end
      end
   end

   assign core_ready    = m_ready;
   assign core_data_out = m_out;

   always @(negedge clk) begin
      if (core_start) begin
         n_starts   <= n_starts + 1;
         last_start <= cyc;
      end
   end

   function automatic res_t observe();
      return {pass, fail, timeout, rt_ok, run_count, disp_data};
   endfunction

   task automatic press(input logic s, input logic m, input logic p, input logic n);
      @(posedge clk); #1;
      btn_start = s; btn_mode = m; btn_prev = p; btn_next = n;
      repeat (DB + 4) @(posedge clk);
      #1;
      btn_start = 0; btn_mode = 0; btn_prev = 0; btn_next = 0;
      repeat (DB + 4) @(posedge clk);
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (vec_mode !== 1'b1) begin
         n_fail++; $display("FAIL reset_vec_mode got=%b exp=1", vec_mode);
      end
      n_tests++;
      if ({busy, pass, fail, timeout, rt_ok, core_start} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_status got=%b exp=000000",
                  {busy, pass, fail, timeout, rt_ok, core_start});
      end
      n_tests++;
      if ({run_count, vec_sel, disp_group, disp_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_counters run=%0d sel=%0d grp=%0d disp=%h exp=all 0",
                  run_count, vec_sel, disp_group, disp_data);
      end
      n_tests++;
      if ({core_enc_dec, core_data_in, core_key} !== '0) begin
         n_fail++;
         $display("FAIL reset_operands enc=%b din=%h key=%h exp=0",
                  core_enc_dec, core_data_in, core_key);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_debounce_pass();
      bit   ok;
      int   s0;
      res_t got, e;
      s0 = n_starts;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, RT, 8'd1, 32'h70b4c55a});
      @(posedge clk); #1; btn_start = 1;
      repeat (2) @(posedge clk);
      #1; btn_start = 0;
      repeat (2) @(posedge clk);
      #1; btn_start = 1;
      repeat (DB + 2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL debounce_early busy=%b exp=0", busy);
      end
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL debounce_latency busy=%b exp=1", busy);
      end
      repeat (40) @(posedge clk);
      #1; btn_start = 0;
      repeat (DB + 4) @(posedge clk);
      wait_idle(ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL debounce_idle busy=%b exp=0", busy);
      end
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (got !== e) begin
         n_fail++; $display("FAIL pass_vector got=%h exp=%h", got, e);
      end
      n_tests++;
      if (n_starts - s0 !== (RT ? 2 : 1)) begin
         n_fail++;
         $display("FAIL start_pulses got=%0d exp=%0d", n_starts - s0, RT ? 2 : 1);
      end
   endtask

   task automatic test_wrong();
      bit   ok;
      res_t got, e;
      core_mode = 1;
      sb_q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 32'h8f4b3aa5});
      press(1, 0, 0, 0);
      wait_idle(ok);
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (!ok || got !== e) begin
         n_fail++; $display("FAIL wrong_result ok=%b got=%h exp=%h", ok, got, e);
      end
   endtask

   task automatic test_timeout();
      bit   ok;
      int   dt;
      res_t got, e;
      core_mode = 2;
      sb_q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 32'h8f4b3aa5});
      press(1, 0, 0, 0);
      ok = 1'b0;
      for (int i = 0; i < TO + 50; i++) begin
         @(negedge clk);
         if (timeout) begin
            ok = 1'b1;
            break;
         end
      end
      dt = cyc - last_start;
      n_tests++;
      if (!ok || dt < TO || dt > TO + 2) begin
         n_fail++;
         $display("FAIL timeout_delay seen=%b cycles=%0d exp=%0d..%0d", ok, dt, TO, TO + 2);
      end
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (got !== e || busy !== 1'b0) begin
         n_fail++; $display("FAIL timeout_status busy=%b got=%h exp=%h", busy, got, e);
      end
      core_mode = 0;
   endtask

   task automatic test_groups();
      repeat (5) press(0, 0, 0, 1);
      @(negedge clk);
      n_tests++;
      if (disp_group !== GW'(1) || disp_data !== 32'h2732487f) begin
         n_fail++;
         $display("FAIL next_wrap grp=%0d disp=%h exp grp=1 disp=2732487f", disp_group, disp_data);
      end
      press(0, 0, 1, 0);
      @(negedge clk);
      n_tests++;
      if (disp_group !== GW'(0)) begin
         n_fail++; $display("FAIL prev_step grp=%0d exp=0", disp_group);
      end
      press(0, 0, 1, 0);
      @(negedge clk);
      n_tests++;
      if (disp_group !== GW'(3) || disp_data !== 32'h963b1f27) begin
         n_fail++;
         $display("FAIL prev_wrap grp=%0d disp=%h exp grp=3 disp=963b1f27", disp_group, disp_data);
      end
      press(0, 0, 1, 1);
      @(negedge clk);
      n_tests++;
      if (disp_group !== GW'(3)) begin
         n_fail++; $display("FAIL next_prev_both grp=%0d exp=3", disp_group);
      end
      press(0, 0, 0, 1);
   endtask

   task automatic test_decrypt();
      bit   ok;
      res_t got, e;
      press(0, 1, 0, 0);
      n_tests++;
      if (vec_mode !== 1'b0) begin
         n_fail++; $display("FAIL mode_toggle vec_mode=%b exp=0", vec_mode);
      end
      sb_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 32'hccddeeff});
      press(1, 0, 0, 0);
      wait_idle(ok);
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (!ok || got !== e || core_enc_dec !== 1'b0) begin
         n_fail++;
         $display("FAIL decrypt ok=%b enc=%b got=%h exp=%h", ok, core_enc_dec, got, e);
      end
      press(0, 1, 0, 0);
      n_tests++;
      if (vec_mode !== 1'b1) begin
         n_fail++; $display("FAIL mode_back vec_mode=%b exp=1", vec_mode);
      end
   endtask

   task automatic test_busy_ignore();
      bit   ok;
      res_t got, e;
      lat = 40;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, RT, 8'd4, 32'h70b4c55a});
      press(1, 0, 0, 0);
      vec_sel_in = 4'd5;
      press(1, 1, 0, 0);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || vec_sel !== 4'd0) begin
         n_fail++; $display("FAIL sel_frozen busy=%b sel=%0d exp busy=1 sel=0", busy, vec_sel);
      end
      wait_idle(ok);
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (!ok || got !== e || vec_mode !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_ignore ok=%b mode=%b got=%h exp=%h", ok, vec_mode, got, e);
      end
      repeat (30) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || run_count !== 8'd4 || vec_sel !== 4'd5) begin
         n_fail++;
         $display("FAIL no_queued_start busy=%b run=%0d sel=%0d exp busy=0 run=4 sel=5",
                  busy, run_count, vec_sel);
      end
      vec_sel_in = '0;
      lat = 3;
   endtask

   task automatic test_reset_mid();
      bit   ok;
      res_t got, e;
      lat = 40;
      press(1, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || core_ready !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset busy=%b ready=%b exp busy=1 ready=0", busy, core_ready);
      end
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy, pass, fail, timeout, rt_ok, core_start, run_count, vec_mode, disp_data} !==
          {6'b0, 8'd0, 1'b1, 32'd0}) begin
         n_fail++;
         $display("FAIL mid_reset busy=%b p=%b f=%b t=%b rt=%b st=%b run=%0d mode=%b disp=%h",
                  busy, pass, fail, timeout, rt_ok, core_start, run_count, vec_mode, disp_data);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (60) @(posedge clk);
      lat = 3;
      sb_q.push_back('{1'b1, 1'b0, 1'b0, RT, 8'd1, 32'h70b4c55a});
      press(1, 0, 0, 0);
      wait_idle(ok);
      got = observe();
      e   = sb_q.pop_front();
      n_tests++;
      if (!ok || got !== e) begin
         n_fail++; $display("FAIL after_reset ok=%b got=%h exp=%h", ok, got, e);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_debounce_pass();
      test_wrong();
      test_timeout();
      test_groups();
      test_decrypt();
      test_busy_ignore();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_fpga_ctrl.md
Name: aes_fpga_ctrl

Overview:
Parametrised board-level test controller for the AES core. Replaces free-running button sampling with per-button debounce. Drives the core through a start/ready handshake with timeout, and self-checks the result against an expected value from the vector ROM. Captures the result for a generic N-digit 7-segment driver, paging through it in groups. Sits between board I/O, the vector ROM, the AES core and the 7-segment controller.

Parameters:
DATA_W, 128, data/key/result width; must be a multiple of 4*NUM_DIGITS
NUM_DIGITS, 8, hex digits shown at once; NUM_GROUPS = DATA_W/(4*NUM_DIGITS), GRP_W = max(1, clog2(NUM_GROUPS))
VEC_SEL_W, 4, width of the vector selection
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must hold before it is accepted
TIMEOUT_CYCLES, 4096, maximum cycles from core_start to result before abort

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
btn_start, btn_mode, btn_prev, btn_next  in  1 each  raw asynchronous push buttons
vec_sel_in  in  VEC_SEL_W  switch-selected vector index
vec_data, vec_key, vec_exp  in  DATA_W each  ROM outputs for (vec_sel, vec_mode); combinational
vec_sel  out  VEC_SEL_W  index presented to ROM
vec_mode  out  1  1=encrypt, 0=decrypt; presented to ROM
core_start  out  1  one-cycle start pulse
core_enc_dec  out  1  mode to core
core_data_in, core_key  out  DATA_W each  registered operands
core_data_out  in  DATA_W  core result
core_ready  in  1  core idle/result-valid level
disp_data  out  4*NUM_DIGITS  selected slice of the result register
disp_group  out  GRP_W  current page
busy, pass, fail, timeout, rt_ok  out  1 each  status
run_count  out  8  completed runs, saturating at 255

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0 except vec_mode=1. Result register, debounce state and counters cleared. FSM goes to IDLE. Applies mid-operation too; core_start is never left high.
- Debounce, per button:
  - 2-flop synchroniser, then a counter that clears whenever the synchronised level differs from the accepted level.
  - New level accepted when the counter reaches DEBOUNCE_CYCLES-1.
  - A rising edge of the accepted level gives a 1-cycle pulse.
  - Raw-to-pulse latency = DEBOUNCE_CYCLES+2 cycles.
- mode pulse: toggles vec_mode in IDLE/DONE only; ignored while busy.
- next/prev pulses: disp_group +1/-1 with wrap (NUM_GROUPS-1 <-> 0). Allowed in any state. Simultaneous next and prev: no change.
- vec_sel follows vec_sel_in in IDLE/DONE and is frozen while busy.
- FSM states:
  - IDLE/DONE: on start pulse go to LOAD. busy=1 from LOAD until DONE.
  - LOAD (1 cycle): register vec_data, vec_key, vec_exp and vec_mode into core_data_in, core_key, exp_reg and core_enc_dec. Clear pass, fail, timeout and rt_ok.
  - START (1 cycle): core_start=1. Timeout counter cleared.
  - WAIT_LO: wait for core_ready=0.
  - WAIT_HI: wait for core_ready=1, then capture core_data_out into res_reg and go to CHECK. A core whose ready never drops times out.
  - Timeout counter runs in WAIT_LO/WAIT_HI. On reaching TIMEOUT_CYCLES-1: timeout=1, fail=1, res_reg unchanged, go to DONE.
  - CHECK (1 cycle): pass = (res_reg==exp_reg), fail = ~pass. run_count++ (saturating). Go to DONE.
- Start pulse while busy is ignored (not queued).
- disp_data = res_reg[disp_group*4*NUM_DIGITS +: 4*NUM_DIGITS]. Group 0 is the least-significant slice.
- Latency from start pulse to pass/fail (ideal core with ready drop next cycle and result after L cycles): 4+L cycles.

Optional Feature:
AES_CTRL_ROUNDTRIP_EN
- Defined: after CHECK with core_enc_dec=1, go to LOAD_RT. LOAD_RT loads core_data_in=res_reg, core_enc_dec=0, key unchanged, and keeps the original plaintext in pt_reg. It then runs START/WAIT_LO/WAIT_HI again (timeout applies) into CHECK_RT.
  - CHECK_RT sets rt_ok=(core_data_out==pt_reg), then goes to DONE.
  - res_reg keeps the ciphertext.
  - busy stays 1 throughout.
  - run_count increments once per start.
- Undefined: rt_ok tied 0, no pt_reg, no round-trip states.

Decomposition:
- Package aes_fpga_pkg: FSM state enum, DATA_W default, NUM_GROUPS/GRP_W helper functions, timeout constant.
- Sub-module btn_debounce (one per button, parameter DEBOUNCE_CYCLES): synchroniser, counter and rising-edge pulse.

Test Plan:
- DEBOUNCE_CYCLES=4. btn_start bounce 1,0,1 of 2-cycle pulses, then held -> exactly one internal pulse, DEBOUNCE_CYCLES+2 cycles after the stable level.
- vec_mode=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, exp 69c4e0d86a7b0430d8cdb78070b4c55a; model core returns exp -> pass=1, fail=0, run_count=1, disp_group 0 shows 70b4c55a.
- Same vector, model returns the wrong value -> fail=1, pass=0. Model never raises ready -> timeout=1 and fail=1 at TIMEOUT_CYCLES, busy=0.
- next pressed 5 times (NUM_GROUPS=4) -> disp_group=1; prev at 0 -> 3. mode and start pressed during busy -> vec_mode and run unchanged.
- rst_n=0 during WAIT_HI -> next cycle all status outputs=0, core_start=0, IDLE; a new start works normally.
- With AES_CTRL_ROUNDTRIP_EN and a FIPS C.1 model core -> pass=1, rt_ok=1, two core_start pulses, res_reg = ciphertext.
